// File: rtl/hazard_regfile_pkg.sv
// -----------------------------------------------------------------------------
// hazard_regfile_pkg
//   Shared definitions for the hazard-tracking register file.
//   - slot_t        : record kept for every in-flight pipeline slot
//   - SLOT_EX/MEM/WB: slot indices for the default three-slot pipeline
//   - SLOT_WD_W     : stored destination width; ADDR_W must not exceed it
// -----------------------------------------------------------------------------
package hazard_regfile_pkg;

  localparam int SLOT_EX   = 0;
  localparam int SLOT_MEM  = 1;
  localparam int SLOT_WB   = 2;

  // Destination field is sized for the widest supported address; narrower
  // addresses are zero-extended so comparisons use the full field.
  localparam int SLOT_WD_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 wreg;
    logic                 late;
    logic [SLOT_WD_W-1:0] wd;
  } slot_t;

  function automatic slot_t make_slot(input logic                 valid,
                                      input logic                 wreg,
                                      input logic                 late,
                                      input logic [SLOT_WD_W-1:0] wd);
    slot_t s;
    s.valid = valid;
    s.wreg  = wreg;
    s.late  = late;
    s.wd    = wd;
    return s;
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// -----------------------------------------------------------------------------
// hazard_slot_pipe
//   Shift register of in-flight instruction records (slot 0 = EX ...
//   slot PIPE_DEPTH-1 = WB). Every slot advances every cycle; the hold input
//   only decides whether the presented issue enters slot 0.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   issue_valid/wreg/wd/late : instruction presented by ID
//   hold                     : hazard stall; blocks the issue from entering
//   flush                    : kills the issue and drops the current EX entry
//   slot_valid/wreg/late     : per-slot flags, bit k = slot k
//   slot_wd                  : per-slot destination, SLOT_WD_W bits per slot
// -----------------------------------------------------------------------------
module hazard_slot_pipe
  import hazard_regfile_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  input  logic                            issue_wreg,
  input  logic [ADDR_W-1:0]               issue_wd,
  input  logic                            issue_late,
  input  logic                            hold,
  input  logic                            flush,
  output logic [PIPE_DEPTH-1:0]           slot_valid,
  output logic [PIPE_DEPTH-1:0]           slot_wreg,
  output logic [PIPE_DEPTH-1:0]           slot_late,
  output logic [PIPE_DEPTH*SLOT_WD_W-1:0] slot_wd
);

  slot_t slot_q [PIPE_DEPTH];
  slot_t slot_d [PIPE_DEPTH];

  always_comb begin
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      slot_d[k] = '0;
    end
    // Issue handshake: the ID instruction is accepted when issue_valid is
    // high and hold is low (hold acts as !ready); flush overrides both.
    if (issue_valid && !hold && !flush) begin
      slot_d[SLOT_EX] = make_slot(1'b1, issue_wreg, issue_late,
                                  SLOT_WD_W'(issue_wd));
    end
    // A flushed EX entry turns into a bubble as it moves to MEM.
    slot_d[SLOT_MEM] = flush ? slot_t'('0) : slot_q[SLOT_EX];
    for (int k = 2; k < PIPE_DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  always_comb begin
    slot_valid = '0;
    slot_wreg  = '0;
    slot_late  = '0;
    slot_wd    = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      slot_valid[k]                       = slot_q[k].valid;
      slot_wreg[k]                        = slot_q[k].wreg;
      slot_late[k]                        = slot_q[k].late;
      slot_wd[k*SLOT_WD_W +: SLOT_WD_W]   = slot_q[k].wd;
    end
  end

endmodule

// File: rtl/hazard_regfile.sv
// -----------------------------------------------------------------------------
// hazard_regfile
//   Register file with read-after-write hazard tracking and result bypass.
//   Register 0 reads as zero and is never written or matched.
// Configuration macro: HAZARD_FWD_EN
//   defined   : forward from any ready matching slot (EX only when not late)
//   undefined : forward from the WB slot only; any younger match stalls
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rd_en        : per-port read enable (NUM_RD bits)
//   rd_addr      : per-port read address (ADDR_W bits per port)
//   rd_data      : per-port combinational read data (DATA_W bits per port)
//   issue_*      : instruction presented by ID for EX
//   stage_wdata  : result value presented by each slot (DATA_W bits per slot)
//   flush        : kill current issue and invalidate slot 0
//   stall_o      : unresolved read-after-write hazard; ID holds
// -----------------------------------------------------------------------------
module hazard_regfile
  import hazard_regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_RD     = 2,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  input  logic                         issue_valid,
  input  logic                         issue_wreg,
  input  logic [ADDR_W-1:0]            issue_wd,
  input  logic                         issue_late,
  input  logic [PIPE_DEPTH*DATA_W-1:0] stage_wdata,
  input  logic                         flush,
  output logic                         stall_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int WB    = PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0]           slot_valid;
  logic [PIPE_DEPTH-1:0]           slot_wreg;
  logic [PIPE_DEPTH-1:0]           slot_late;
  logic [PIPE_DEPTH*SLOT_WD_W-1:0] slot_wd;

  logic [DATA_W-1:0]               regs_q [DEPTH];
  logic [DATA_W-1:0]               regs_d [DEPTH];

  logic [SLOT_WD_W-1:0]            wb_wd;
  logic                            wb_we;
  logic [NUM_RD-1:0]               port_stall;

  hazard_slot_pipe #(
    .ADDR_W     (ADDR_W),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_slot_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_wreg  (issue_wreg),
    .issue_wd    (issue_wd),
    .issue_late  (issue_late),
    .hold        (stall_o),
    .flush       (flush),
    .slot_valid  (slot_valid),
    .slot_wreg   (slot_wreg),
    .slot_late   (slot_late),
    .slot_wd     (slot_wd)
  );

  // ---------------------------------------------------------------------------
  // Register array, written from the WB slot
  // ---------------------------------------------------------------------------
  assign wb_wd = slot_wd[WB*SLOT_WD_W +: SLOT_WD_W];
  assign wb_we = slot_valid[WB] && slot_wreg[WB] && (wb_wd != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_we) begin
      regs_d[wb_wd[ADDR_W-1:0]] = stage_wdata[WB*DATA_W +: DATA_W];
    end
  end

  // Reset wins over a pending WB write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port hazard detection and bypass
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0]    addr;
    logic [SLOT_WD_W-1:0] addr_ext;
    logic                 active;
    logic                 hit;
    logic                 fwd_ok;
    logic [DATA_W-1:0]    hit_data;

    assign addr     = rd_addr[p*ADDR_W +: ADDR_W];
    assign addr_ext = SLOT_WD_W'(addr);
    // r0 and disabled ports never look at the slots.
    assign active   = rd_en[p] && !rst && (addr != '0);

    always_comb begin
      hit      = 1'b0;
      fwd_ok   = 1'b0;
      hit_data = '0;
      // Walk oldest to youngest so the youngest match is the one left.
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
        if (slot_valid[k] && slot_wreg[k] &&
            (slot_wd[k*SLOT_WD_W +: SLOT_WD_W] == addr_ext)) begin
          hit      = 1'b1;
          hit_data = stage_wdata[k*DATA_W +: DATA_W];
`ifdef HAZARD_FWD_EN
          fwd_ok   = (k >= SLOT_MEM) || !slot_late[k];
`else
          fwd_ok   = (k == WB);
`endif
        end
      end
    end

    assign port_stall[p] = active && hit && !fwd_ok;
    // A stalled port returns zero; the value is ignored while ID holds.
    assign rd_data[p*DATA_W +: DATA_W] =
      !active ? '0 :
      hit     ? (fwd_ok ? hit_data : '0) :
                regs_q[addr];
  end

`ifndef HAZARD_FWD_EN
  // Late flag only matters when forwarding from EX is possible.
  logic unused_slot_late;
  assign unused_slot_late = ^slot_late;
`endif

  assign stall_o = |port_stall;

endmodule

// File: tb/tb_hazard_regfile.sv
module tb_hazard_regfile;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int NUM_RD     = 2;
  localparam int PIPE_DEPTH = 3;
  localparam int EW         = 1 + NUM_RD * DATA_W;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD*ADDR_W-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0]     rd_data;
  logic                         issue_valid;
  logic                         issue_wreg;
  logic [ADDR_W-1:0]            issue_wd;
  logic                         issue_late;
  logic [PIPE_DEPTH*DATA_W-1:0] stage_wdata;
  logic                         flush;
  logic                         stall_o;

  hazard_regfile #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_RD     (NUM_RD),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .issue_valid (issue_valid),
    .issue_wreg  (issue_wreg),
    .issue_wd    (issue_wd),
    .issue_late  (issue_late),
    .stage_wdata (stage_wdata),
    .flush       (flush),
    .stall_o     (stall_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: expected {stall, d1, d0}
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_vec  = 0;
  int            n_err  = 0;
  logic          mon_en = 1'b0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle();
    rst         = 1'b0;
    rd_en       = '0;
    rd_addr     = '0;
    issue_valid = 1'b0;
    issue_wreg  = 1'b0;
    issue_wd    = '0;
    issue_late  = 1'b0;
    stage_wdata = '0;
    flush       = 1'b0;
  endtask

  task automatic rd(input int p, input logic [ADDR_W-1:0] a);
    rd_en[p]                     = 1'b1;
    rd_addr[p*ADDR_W +: ADDR_W]  = a;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] wd, input logic late);
    issue_valid = 1'b1;
    issue_wreg  = 1'b1;
    issue_wd    = wd;
    issue_late  = late;
  endtask

  task automatic stage(input int k, input logic [DATA_W-1:0] v);
    stage_wdata[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic push_exp(input string nm, input logic s,
                          input logic [DATA_W-1:0] d0,
                          input logic [DATA_W-1:0] d1);
    exp_q.push_back({s, d1, d0});
    name_q.push_back(nm);
    mon_en = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    idle();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge whenever a vector is presented
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL monitor: output presented but no expectation queued");
      end else begin
        logic [EW-1:0] e;
        string         nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if ({stall_o, rd_data} !== e) begin
          n_err++;
          $display("FAIL %s: got stall=%0b d1=%h d0=%h, required stall=%0b d1=%h d0=%h",
                   nm, stall_o, rd_data[2*DATA_W-1:DATA_W], rd_data[DATA_W-1:0],
                   e[EW-1], e[2*DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset behaviour
    rst = 1'b1; rd(0, 5'd1); rd(1, 5'd2);
    push_exp("rst_hold", 1'b0, 32'h0, 32'h0); tick();
    rd(0, 5'd1); rd(1, 5'd31);
    push_exp("reset_state", 1'b0, 32'h0, 32'h0); tick();

    // Non-late producer, consumer right behind it
    issue(5'd3, 1'b0); tick();
    rd(0, 5'd3); stage(0, 32'h11);
    push_exp("fwd_ex", !FWD, FWD ? 32'h11 : 32'h0, 32'h0); tick();
    rd(0, 5'd3); stage(1, 32'h11);
    push_exp("fwd_mem", !FWD, FWD ? 32'h11 : 32'h0, 32'h0); tick();
    rd(0, 5'd3); stage(2, 32'h11);
    push_exp("wb_thru_r3", 1'b0, 32'h11, 32'h0); tick();
    rd(0, 5'd3); rd(1, 5'd3);
    push_exp("array_r3", 1'b0, 32'h11, 32'h11); tick();

    // Load-use: one stall cycle; the held issue of r6 must not enter
    issue(5'd5, 1'b1); tick();
    rd(0, 5'd5); stage(0, 32'h99); issue(5'd6, 1'b0);
    rd_addr[ADDR_W +: ADDR_W] = 5'd5;
    push_exp("load_use", 1'b1, 32'h0, 32'h0); tick();
    rd(0, 5'd5); stage(1, 32'h22);
    push_exp("load_mem", !FWD, FWD ? 32'h22 : 32'h0, 32'h0); tick();
    rd(0, 5'd5); rd(1, 5'd6); stage(2, 32'h22);
    push_exp("load_wb", 1'b0, 32'h22, 32'h0); tick();
    rd(0, 5'd5); rd(1, 5'd6);
    push_exp("array_r5_r6", 1'b0, 32'h22, 32'h0); tick();

    // Two writes to r7 in flight: slot 0 (0xA) and slot 2 (0xB)
    issue(5'd7, 1'b0); tick();
    tick();
    issue(5'd7, 1'b0); tick();
    rd(0, 5'd7); rd(1, 5'd7); stage(0, 32'hA); stage(2, 32'hB);
    push_exp("youngest", !FWD, FWD ? 32'hA : 32'h0, FWD ? 32'hA : 32'h0); tick();
    rd(0, 5'd7); rd_addr[ADDR_W +: ADDR_W] = 5'd7; stage(1, 32'hA);
    push_exp("young_mem", !FWD, FWD ? 32'hA : 32'h0, 32'h0); tick();
    rd(0, 5'd7); rd(1, 5'd7); stage(2, 32'hA);
    push_exp("young_wb", 1'b0, 32'hA, 32'hA); tick();
    rd(0, 5'd7); rd(1, 5'd7);
    push_exp("array_r7", 1'b0, 32'hA, 32'hA); tick();

    // Writes to r0 are ignored and never hazard
    issue(5'd0, 1'b0); tick();
    rd(0, 5'd0); rd(1, 5'd0); stage(0, 32'hFF);
    push_exp("r0_ex", 1'b0, 32'h0, 32'h0); tick();
    rd(0, 5'd0); rd(1, 5'd0); stage(1, 32'hFF);
    push_exp("r0_mem", 1'b0, 32'h0, 32'h0); tick();
    rd(0, 5'd0); rd(1, 5'd0); stage(2, 32'hFF);
    push_exp("r0_wb", 1'b0, 32'h0, 32'h0); tick();
    rd(0, 5'd0); rd(1, 5'd0);
    push_exp("r0_array", 1'b0, 32'h0, 32'h0); tick();

    // Flush: r4 holds 0x44, flushed write of 0x55 must never land
    issue(5'd4, 1'b0); tick();
    tick();
    tick();
    rd(0, 5'd4); stage(2, 32'h44);
    push_exp("r4_wb", 1'b0, 32'h44, 32'h0); tick();
    issue(5'd4, 1'b0); rd(0, 5'd4);
    push_exp("r4_prior", 1'b0, 32'h44, 32'h0); tick();
    flush = 1'b1; issue(5'd8, 1'b0); stage(0, 32'h55); tick();
    rd(0, 5'd4); rd(1, 5'd8); stage(1, 32'h55);
    push_exp("flush_mem", 1'b0, 32'h44, 32'h0); tick();
    rd(0, 5'd4); rd(1, 5'd8); stage(2, 32'h55);
    push_exp("flush_wb", 1'b0, 32'h44, 32'h0); tick();
    rd(0, 5'd4); rd(1, 5'd8);
    push_exp("flush_after", 1'b0, 32'h44, 32'h0); tick();

    // Disabled ports see nothing even with a late producer in EX
    issue(5'd11, 1'b1); tick();
    rd_addr = {5'd11, 5'd11}; stage(0, 32'h77);
    push_exp("rd_en_off", 1'b0, 32'h0, 32'h0); tick();
    tick();
    tick();

    // Reset with r9 in WB and r10 in MEM
    issue(5'd9, 1'b0); tick();
    issue(5'd10, 1'b0); tick();
    tick();
    rst = 1'b1; stage(2, 32'h33); rd(0, 5'd9); rd(1, 5'd10);
    push_exp("rst_mid", 1'b0, 32'h0, 32'h0); tick();
    rd(0, 5'd9); rd(1, 5'd10); stage(2, 32'h44); stage(1, 32'h44);
    push_exp("post_rst", 1'b0, 32'h0, 32'h0); tick();
    rd(0, 5'd3); rd(1, 5'd7);
    push_exp("regs_cleared", 1'b0, 32'h0, 32'h0); tick();
    rd(0, 5'd9); rd(1, 5'd10);
    push_exp("r9_r10_final", 1'b0, 32'h0, 32'h0); tick();

    tick();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    // -------------------------------------------------------------------------
    // Final report
    // -------------------------------------------------------------------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_regfile.md
HAZARD_REGFILE -- requirements
Module: hazard_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning read port count.
REQ-004 SHALL have parameter PIPE_DEPTH, default 3, meaning number of tracked in-flight slots (slot 0 = EX … slot PIPE_DEPTH-1 = WB); minimum 2.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rd_en, input, NUM_RD, per-port read enable.
REQ-008 SHALL have port rd_addr, input, NUM_RD*ADDR_W, per-port read address.
REQ-009 SHALL have port rd_data, output, NUM_RD*DATA_W, per-port read data.
REQ-010 SHALL have port issue_valid, input, 1, ID presents an instruction for EX this cycle.
REQ-011 SHALL have port issue_wreg, input, 1, issued instruction writes a register.
REQ-012 SHALL have port issue_wd, input, ADDR_W, issued destination register.
REQ-013 SHALL have port issue_late, input, 1, result first available in slot 1 (load).
REQ-014 SHALL have port stage_wdata, input, PIPE_DEPTH*DATA_W, result value presented by each slot this cycle.
REQ-015 SHALL have port flush, input, 1, kill current issue and invalidate slot 0.
REQ-016 SHALL have port stall_o, output, 1, unresolved read-after-write hazard; ID holds.

Function
REQ-017 SHALL keep per slot: valid, wreg, wd, late; advance slot k to k+1 every cycle regardless of stall_o.
REQ-018 SHALL load slot 0 with the issue fields when issue_valid && !stall_o && !flush, else a bubble (valid=0).
REQ-019 SHALL, on flush, set slot 1 from a bubble in place of slot 0's contents (the flushed EX entry is dropped); slots >=2 advance normally.
REQ-020 SHALL write stage_wdata[PIPE_DEPTH-1] into register wd at the clock edge when slot PIPE_DEPTH-1 is valid, wreg=1 and wd!=0.
REQ-021 SHALL return 0 for register 0 on every port; register 0 never written, never matched as hazard.
REQ-022 SHALL produce rd_data combinationally; rd_en=0 gives rd_data=0 and no stall contribution.
REQ-023 SHALL, per enabled port, select the youngest (lowest k) valid slot with wreg=1 and wd==rd_addr; no match reads the array.
REQ-024 SHALL treat a matched slot as ready when k>=1, or k==0 and late=0.
REQ-025 SHALL forward stage_wdata[k] of a ready matched slot; a non-ready match asserts stall_o.
REQ-026 SHALL OR stall contributions of all ports into stall_o; stall_o is combinational from slots and read requests.
REQ-027 SHALL give identical results when multiple ports read the same address.

Reset
REQ-028 SHALL, on rst, clear all slot valid bits and all registers to 0.
REQ-029 SHALL drive rd_data=0 and stall_o=0 while rst is high.
REQ-030 SHALL discard in-flight slots on reset mid-operation; pending WB write on the reset edge is not performed.

Configuration
REQ-031 SHALL use macro HAZARD_FWD_EN: defined, forwarding per REQ-023..REQ-025.
REQ-032 SHALL, without HAZARD_FWD_EN, forward only slot PIPE_DEPTH-1 (WB write-through); any younger match asserts stall_o.

Structure
REQ-033 SHALL place slot record typedef and slot-index constants (SLOT_EX, SLOT_MEM, SLOT_WB) in the shared defines package.
REQ-034 SHALL instantiate one sub-module hazard_slot_pipe holding the slot shift register; bypass mux and array stay in top.

Verification
REQ-035 SHALL cover: issue wd=3 non-late, next cycle read r3 with stage_wdata[0]=0x11 -> rd_data=0x11, stall_o=0 (FWD_EN); stall_o=1 without it.
REQ-036 SHALL cover: issue load wd=5 late=1, next cycle read r5 -> stall_o=1 one cycle, then rd_data=stage_wdata[1]=0x22.
REQ-037 SHALL cover: two in-flight writes to r7 (slots 0 and 2, values 0xA, 0xB) -> rd_data=0xA (youngest wins).
REQ-038 SHALL cover: issue wd=0 value 0xFF, read r0 on both ports through WB -> rd_data=0, stall_o=0, r0 unchanged.
REQ-039 SHALL cover: flush with slot 0 wd=4 -> no later write to r4, read r4 returns prior array value, stall_o=0.
REQ-040 SHALL cover: rst asserted with slot WB valid wd=9 value 0x33 -> r9 reads 0 after reset, stall_o=0.
